// File: rtl/mem_responder_if.sv
// Request/response bus between the P4 memory-access initiator and the memory responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_wren;
    logic [15:0] req_address;
    logic [15:0] req_data;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_data;

    // Initiator side: drives requests, observes handshake and responses.
    modport master (
        output req_valid, req_wren, req_address, req_data,
        input  req_ready, resp_valid, resp_data
    );

    // Responder side: observes requests, drives handshake and responses.
    modport slave (
        input  req_valid, req_wren, req_address, req_data,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, serviced after LATENCY wait cycles,
// targeting a word-addressed RAM or the MMIO page at 0xFFxx.
module mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_responder_if.slave        bus,
    input  logic [15:0]           io_in,
    output logic [15:0]           io_out,
    output logic                  addr_err
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_BITS;

    // Reject wait counts the 4-bit counter cannot express.
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic                wren_q,       wren_d;
    logic [15:0]         addr_q,       addr_d;
    logic [DATA_W-1:0]   data_q,       data_d;
    logic                req_ready_q,  req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q,  resp_data_d;
    logic [DATA_W-1:0]   io_out_q,     io_out_d;
    logic                addr_err_q,   addr_err_d;
    logic [15:0]         req_count_q,  req_count_d;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic                access_c;
    logic                is_mmio_c;
    logic [ADDR_BITS-1:0] idx_c;
    logic [DATA_W-1:0]   rd_data_c;

    assign access_c  = (state_q == BUSY) && (cnt_q == '0);
    assign is_mmio_c = (addr_q[15:8] == 8'hFF);
    assign idx_c     = addr_q[ADDR_BITS-1:0];

    // Read-data source selected by the latched address.
    always_comb begin
        rd_data_c = mem[idx_c];
        if (is_mmio_c) begin
            case (addr_q[7:0])
                8'h00:   rd_data_c = io_in;
                8'h01:   rd_data_c = req_count_q;
                default: rd_data_c = '0;
            endcase
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wren_d       = wren_q;
        addr_d       = addr_q;
        data_d       = data_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        io_out_d     = io_out_q;
        addr_err_d   = addr_err_q;
        req_count_d  = req_count_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wren_d  = bus.req_wren;
                    addr_d  = bus.req_address;
                    data_d  = bus.req_data;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    resp_valid_d = 1'b1;
                    req_count_d  = req_count_q + 16'd1;
                    state_d      = DONE;
                    resp_data_d  = wren_q ? '0 : rd_data_c;
                    if (is_mmio_c) begin
                        if (addr_q[7:0] == 8'h00) begin
                            if (wren_q) io_out_d = data_q;
                        end else if (addr_q[7:0] != 8'h01) begin
                            addr_err_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            io_out_q     <= '0;
            addr_err_q   <= 1'b0;
            req_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            io_out_q     <= io_out_d;
            addr_err_q   <= addr_err_d;
            req_count_q  <= req_count_d;
        end
    end

    // RAM write on the access edge; contents survive reset, and reset blocks a pending write.
    always_ff @(posedge clock) begin
        if (reset && access_c && wren_q && !is_mmio_c) begin
            mem[idx_c] <= data_q;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign io_out         = io_out_q;
    assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expected responses, monitor checks them.
module tb_mem_responder;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic        addr_err;
    int          cyc;
    int          n_cmp;
    int          n_fail;
    exp_t        sb_q[$];

    mem_responder_if bus ();

    mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .io_in    (io_in),
        .io_out   (io_out),
        .addr_err (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (bus.resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got data 0x%0h with empty scoreboard (cycle %0d)",
                         bus.resp_data, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_data", 32'(bus.resp_data), 32'(e.data));
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one request; expectation is pushed just before the accept edge.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] ex, input bit hold);
        int waits;
        waits = 0;
        @(negedge clock);
        bus.req_valid   = 1'b1;
        bus.req_wren    = w;
        bus.req_address = a;
        bus.req_data    = d;
        while (bus.req_ready !== 1'b1 && waits < 64) begin
            @(negedge clock);
            waits++;
        end
        if (waits >= 64) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_timeout: req_ready never rose for addr 0x%0h", a);
            bus.req_valid = 1'b0;
        end else begin
            sb_q.push_back('{data: ex, cyc: cyc + 1 + int'(LAT)});
            @(posedge clock);
            #1;
            if (!hold) bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while ((sb_q.size() != 0 || bus.req_ready !== 1'b1) && waits < 64) begin
            @(negedge clock);
            waits++;
        end
        if (waits >= 64) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp           = 0;
        n_fail          = 0;
        reset           = 1'b0;
        io_in           = 16'h0000;
        bus.req_valid   = 1'b0;
        bus.req_wren    = 1'b0;
        bus.req_address = 16'h0000;
        bus.req_data    = 16'h0000;
        do_reset();

        // Reset state
        @(negedge clock);
        check("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp_data", 32'(bus.resp_data), 32'h0);
        check("rst_io_out", 32'(io_out), 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);

        // Seed 0x0020 with a known value (access 1)
        do_req(1'b1, 16'h0020, 16'h5555, 16'h0000, 1'b0);
        drain();

        // Test 1: write then read back (accesses 2,3)
        do_req(1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0);
        drain();
        do_req(1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0);
        drain();

        // Test 2: alias through ignored high index bits (access 4)
        do_req(1'b0, 16'h0110, 16'h0000, 16'h1234, 1'b0);
        drain();
        check("alias_addr_err", 32'(addr_err), 32'h0);

        // Test 3: MMIO output and input (accesses 5,6)
        do_req(1'b1, 16'hFF00, 16'hA5A5, 16'h0000, 1'b0);
        drain();
        check("io_out_write", 32'(io_out), 32'hA5A5);
        io_in = 16'h00F0;
        do_req(1'b0, 16'hFF00, 16'h0000, 16'h00F0, 1'b0);
        drain();

        // Test 4: held req_valid while busy is not accepted early (access 7, then count read)
        do_req(1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b1);
        @(negedge clock);
        bus.req_address = 16'hFF01;
        check("busy_req_ready", 32'(bus.req_ready), 32'h0);
        do_req(1'b0, 16'hFF01, 16'h0000, 16'd7, 1'b0);
        drain();

        // Test 5: unmapped MMIO sets sticky error; reset clears it and io_out
        do_req(1'b0, 16'hFF7F, 16'h0000, 16'h0000, 1'b0);
        drain();
        check("addr_err_set", 32'(addr_err), 32'h1);
        do_req(1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0);
        drain();
        check("addr_err_sticky", 32'(addr_err), 32'h1);
        do_reset();
        @(negedge clock);
        check("rst2_addr_err", 32'(addr_err), 32'h0);
        check("rst2_io_out", 32'(io_out), 32'h0);
        check("rst2_req_ready", 32'(bus.req_ready), 32'h1);

        // Test 6: reset while busy aborts a pending write
        do_req(1'b1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clock);
        reset = 1'b1;
        check("abort_req_ready", 32'(bus.req_ready), 32'h1);
        repeat (4) @(negedge clock);
        do_req(1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0);
        drain();
        do_req(1'b0, 16'hFF01, 16'h0000, 16'd1, 1'b0);
        drain();

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
